regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (dr / ld_reg / data_in) between two writeback sources: req0 = execute/ALU result, req1 = memory-load return.
- Round-robin arbitration with valid/ready handshakes. One-entry registered commit stage drives the write port.
- Exposes per-read-port hazard flags and bypass data so decode sees in-flight writes.

Parameters:
- DATA_W, 16, data width of each write.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, register count; equals 2**ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  execute write request
- req0_dr  in  ADDR_W  execute destination register
- req0_data  in  DATA_W  execute write data
- req0_ready  out  1  execute request accepted this cycle
- req1_valid  in  1  load write request
- req1_dr  in  ADDR_W  load destination register
- req1_data  in  DATA_W  load write data
- req1_ready  out  1  load request accepted this cycle
- wr_stall  in  1  holds the write port (debug scan / regfile busy)
- wr_en  out  1  to regfile ld_reg
- wr_dr  out  ADDR_W  to regfile dr
- wr_data  out  DATA_W  to regfile data_in
- sr1, sr2  in  ADDR_W  decode read addresses
- sr1_busy, sr2_busy  out  1  in-flight write targets sr1/sr2
- sr1_fwd, sr2_fwd  out  DATA_W  bypass data for the in-flight write
- pending  out  1  commit stage occupied

Behaviour:
- Reset: stage_valid=0, stage_dr=0, stage_data=0, rr_ptr=0 (req0 preferred).
  - All outputs are 0 in the cycle after reset is sampled.
  - Reset mid-operation discards the staged write; no wr_en is issued for it.
- Handshake:
  - A transfer occurs on reqN_valid && reqN_ready.
  - Requesters hold valid, dr and data stable until ready is seen.
  - reqN_ready is combinational: grantN && can_accept.
  - can_accept = !stage_valid || !wr_stall.
- Grant:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is rr_ptr (0 selects req0).
  - rr_ptr flips to the non-winner only when a contested transfer happens. Uncontested transfers leave rr_ptr unchanged.
- Commit stage:
  - States EMPTY / FULL.
  - EMPTY -> FULL on a transfer.
  - FULL with wr_stall=1: hold contents; no transfer is accepted.
  - FULL with wr_stall=0: commit, and reload in the same cycle if a transfer occurs (back-to-back, one write per cycle); otherwise go to EMPTY.
  - wr_en = stage_valid && !wr_stall.
  - wr_dr and wr_data always show the stage contents.
  - Latency: a write accepted in cycle N asserts wr_en in cycle N+1 when unstalled.
- Hazard / bypass (combinational):
  - sr1_busy = stage_valid && stage_dr==sr1; sr2 likewise.
  - sr1_fwd = stage_data when busy, else 0; sr2 likewise.
  - Both ports may flag the same register.
- Same-dr contention:
  - Both requesters with equal dr are serialized in grant order.
  - The loser's value lands last and therefore wins in the regfile.
  - No merging is performed.
- wr_stall held with the stage EMPTY: one transfer is still accepted and then the stage holds.
- Invalid requests: dr/data are ignored; ready may still be asserted (benign, no transfer).

Decomposition:
- Shared package lc3_pkg:
  - reg_addr_t (ADDR_W-bit), word_t (DATA_W-bit).
  - Typedef wb_req_t {valid, dr, data}.
  - Enum stage_state_t {EMPTY, FULL}.
- One sub-module: rr_arbiter2.
  - Two-request round-robin grant with pointer register.
  - Ports: clk, reset, req[1:0], accept, grant[1:0].

Test Plan:
- Reset, then single request: req0 dr=3 data=16'h1234 -> req0_ready=1 in that cycle; next cycle wr_en=1, wr_dr=3, wr_data=16'h1234, pending=1; following cycle pending=0.
- Contention: both valid every cycle, req0 dr=1 data=16'hAAAA, req1 dr=2 data=16'h5555 -> grants alternate 0,1,0,1; wr_en asserted every cycle; no starvation.
- Stall: stage FULL with dr=5, wr_stall=1 for 3 cycles -> wr_en=0 and both readies 0 throughout, stage unchanged; on release, wr_en=1 with dr=5.
- Hazard: stage holds dr=4 data=16'hBEEF, sr1=4, sr2=4 -> sr1_busy=sr2_busy=1, both fwd=16'hBEEF; sr1=0 -> sr1_busy=0, sr1_fwd=0.
- Same dr: both valid with dr=7, rr_ptr=0, data0=16'h0001, data1=16'h0002 -> commits 16'h0001 then 16'h0002 on consecutive cycles.
- Reset mid-op: stage FULL and wr_stall=1, assert reset -> next cycle wr_en=0, pending=0, busy flags 0, and req0 wins the next contested cycle.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared writeback types for the LC-3 register-file write path.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;
    localparam int LC3_ADDR_W = 3;
    localparam int LC3_NUM_REGS = 2 ** LC3_ADDR_W;

    typedef logic [LC3_ADDR_W-1:0] reg_addr_t;
    typedef logic [LC3_DATA_W-1:0] word_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t dr;
        word_t     data;
    } wb_req_t;

    typedef enum logic {EMPTY, FULL} stage_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// rr_arbiter2: two-request round-robin grant; the pointer moves only on contested transfers.
module rr_arbiter2
    import lc3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;

    assign grant[0] = req[0] && (!req[1] || !ptr);
    assign grant[1] = req[1] && (!req[0] || ptr);

    // The loser of a contested transfer becomes preferred next time.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (accept && &req)
            ptr <= grant[0];
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the regfile write port between execute and load
// writeback, with a one-entry commit stage and decode hazard/bypass outputs.
module regfile_wr_arbiter
    import lc3_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_dr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic              sr1_busy,
    output logic              sr2_busy,
    output logic [DATA_W-1:0] sr1_fwd,
    output logic [DATA_W-1:0] sr2_fwd,
    output logic              pending
);

    stage_state_t      state;
    logic [ADDR_W-1:0] stage_dr;
    logic [DATA_W-1:0] stage_data;
    logic [1:0]        grant;
    logic              stage_valid;
    logic              can_accept;
    logic              xfer;

    assign stage_valid = state == FULL;
    assign can_accept  = !stage_valid || !wr_stall;
    assign xfer        = can_accept && (req0_valid || req1_valid);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .accept (can_accept),
        .grant  (grant)
    );

    assign req0_ready = grant[0] && can_accept;
    assign req1_ready = grant[1] && can_accept;

    // A committing stage reloads in the same cycle, giving one write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            stage_dr   <= '0;
            stage_data <= '0;
        end else if (xfer) begin
            state      <= FULL;
            stage_dr   <= grant[1] ? req1_dr : req0_dr;
            stage_data <= grant[1] ? req1_data : req0_data;
        end else if (!wr_stall) begin
            state      <= EMPTY;
        end
    end

    assign wr_en    = stage_valid && !wr_stall;
    assign wr_dr    = stage_dr;
    assign wr_data  = stage_data;
    assign pending  = stage_valid;
    assign sr1_busy = stage_valid && stage_dr == sr1;
    assign sr2_busy = stage_valid && stage_dr == sr2;
    assign sr1_fwd  = sr1_busy ? stage_data : '0;
    assign sr2_fwd  = sr2_busy ? stage_data : '0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random stimulus against a behavioural model,
// with committed writes checked by a scoreboard monitor on wr_en.
module tb_regfile_wr_arbiter;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, wr_stall = 1'b0;
    logic [2:0]  req0_dr = '0, req1_dr = '0, sr1 = '0, sr2 = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, wr_en, sr1_busy, sr2_busy, pending;
    logic [2:0]  wr_dr;
    logic [15:0] wr_data, sr1_fwd, sr2_fwd;

    int checks = 0;
    int errors = 0;

    wb_req_t     exp_q[$];
    logic        m_full = 1'b0;
    logic        m_pref = 1'b0;
    logic [2:0]  m_dr = '0;
    logic [15:0] m_data = '0;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dr    (req0_dr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dr    (req1_dr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_stall   (wr_stall),
        .wr_en      (wr_en),
        .wr_dr      (wr_dr),
        .wr_data    (wr_data),
        .sr1        (sr1),
        .sr2        (sr2),
        .sr1_busy   (sr1_busy),
        .sr2_busy   (sr2_busy),
        .sr1_fwd    (sr1_fwd),
        .sr2_fwd    (sr2_fwd),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Every regfile write must match the oldest accepted request still outstanding.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got dr=%0d data=%h, expected no write", wr_dr, wr_data);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                chk("commit_dr", 32'(wr_dr), 32'(e.dr));
                chk("commit_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic step(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                        input logic st, input logic [2:0] s1, input logic [2:0] s2,
                        input logic rs, output logic acc0, output logic acc1);
        logic    room, w, hit1, hit2;
        wb_req_t e;
        req0_valid = v0; req0_dr = a0; req0_data = d0;
        req1_valid = v1; req1_dr = a1; req1_data = d1;
        wr_stall = st; sr1 = s1; sr2 = s2; reset = rs;
        room = !m_full || !st;
        w = (v0 && v1) ? m_pref : v1;
        acc0 = !rs && room && v0 && !w;
        acc1 = !rs && room && v1 && w;
        hit1 = m_full && m_dr == s1;
        hit2 = m_full && m_dr == s2;
        @(negedge clk);
        if (rs) begin
            m_full = 1'b0;
            m_pref = 1'b0;
            m_dr = '0;
            m_data = '0;
            exp_q.delete();
        end else begin
            chk("req0_ready", 32'(req0_ready), 32'(acc0));
            chk("req1_ready", 32'(req1_ready), 32'(acc1));
            chk("wr_en", 32'(wr_en), 32'(m_full && !st));
            chk("pending", 32'(pending), 32'(m_full));
            chk("sr1_busy", 32'(sr1_busy), 32'(hit1));
            chk("sr2_busy", 32'(sr2_busy), 32'(hit2));
            chk("sr1_fwd", 32'(sr1_fwd), hit1 ? 32'(m_data) : 32'd0);
            chk("sr2_fwd", 32'(sr2_fwd), hit2 ? 32'(m_data) : 32'd0);
            if (acc0 || acc1) begin
                e = '{valid: 1'b1, dr: w ? a1 : a0, data: w ? d1 : d0};
                exp_q.push_back(e);
                m_full = 1'b1;
                m_dr = e.dr;
                m_data = e.data;
                if (v0 && v1) m_pref = !w;
            end else if (!st) begin
                m_full = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st, input logic [2:0] s1, input logic [2:0] s2);
        logic g0, g1;
        step(0, 0, 0, 0, 0, 0, st, s1, s2, 0, g0, g1);
    endtask

    initial begin
        logic        g0, g1, hv0, hv1, rs, st;
        logic [2:0]  ha0, ha1, s1, s2;
        logic [15:0] hd0, hd1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, g0, g1);
        idle(0, 0, 0);
        chk("reset_outputs", 32'({wr_en, wr_dr, wr_data, pending, sr1_busy, sr2_busy, req0_ready, req1_ready}), 32'd0);
        chk("reset_fwd", {sr1_fwd, sr2_fwd}, 32'd0);

        step(1, 3, 16'h1234, 0, 0, 0, 0, 3, 0, 0, g0, g1);
        idle(0, 3, 0);
        idle(0, 3, 0);

        for (int i = 0; i < 6; i++) begin
            step(1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 1, 2, 0, g0, g1);
            chk("alternating_grant", 32'(g1), 32'(i % 2));
        end
        idle(0, 0, 0);

        step(1, 5, 16'h0505, 0, 0, 0, 0, 5, 0, 0, g0, g1);
        for (int i = 0; i < 3; i++) step(1, 1, 16'hAAAA, 1, 2, 16'h5555, 1, 5, 5, 0, g0, g1);
        idle(0, 5, 0);
        idle(0, 0, 0);

        step(1, 4, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        idle(1, 4, 4);
        idle(1, 0, 4);
        idle(0, 4, 4);

        step(1, 7, 16'h0001, 1, 7, 16'h0002, 0, 7, 7, 0, g0, g1);
        chk("same_dr_first_req0", 32'(g0), 32'd1);
        step(0, 0, 0, 1, 7, 16'h0002, 0, 7, 7, 0, g0, g1);
        idle(0, 7, 0);
        idle(0, 0, 0);

        step(1, 6, 16'h6666, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        idle(1, 6, 6);
        step(0, 0, 0, 0, 0, 0, 1, 6, 6, 1, g0, g1);
        idle(0, 6, 6);
        step(1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0, 0, 0, g0, g1);
        chk("post_reset_req0_wins", 32'(g0), 32'd1);
        step(0, 0, 0, 1, 2, 16'h2222, 0, 0, 0, 0, g0, g1);
        idle(0, 0, 0);

        hv0 = 0; hv1 = 0; ha0 = 0; ha1 = 0; hd0 = 0; hd1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hv0) begin hv0 = $urandom_range(0, 2) != 0; ha0 = 3'($urandom); hd0 = 16'($urandom); end
            if (!hv1) begin hv1 = $urandom_range(0, 2) != 0; ha1 = 3'($urandom); hd1 = 16'($urandom); end
            rs = $urandom_range(0, 79) == 0;
            st = rs || $urandom_range(0, 3) == 0;
            s1 = $urandom_range(0, 1) ? m_dr : 3'($urandom);
            s2 = $urandom_range(0, 1) ? m_dr : 3'($urandom);
            if (rs) begin
                hv0 = 0;
                hv1 = 0;
            end
            step(hv0, ha0, hd0, hv1, ha1, hd1, st, s1, s2, rs, g0, g1);
            if (g0) hv0 = 0;
            if (g1) hv1 = 0;
        end
        idle(0, 0, 0);
        idle(0, 0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
